// File: rtl/arm7tdmi_hw_mem_ctrl.sv
// arm7tdmi_hw_mem_ctrl: sequencer for STRH / LDRH / LDRSB / LDRSH transfers.
// It computes the effective address and drives the byte lanes. It holds the access
// across wait states, then extends load data and returns the Rd / Rn writes.
// Optional feature macro: ARM7TDMI_HW_ALIGN_CHECK_EN. When it is defined, a misaligned
// halfword access raises a one-cycle abort instead of being force-aligned.
module arm7tdmi_hw_mem_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [1:0]  req_sh,
    input  logic        req_pre,
    input  logic        req_up,
    input  logic        req_wb,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_sdata,
    input  logic [3:0]  req_rd,
    input  logic [3:0]  req_rn,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        rd_we,
    output logic [3:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic        rn_we,
    output logic [3:0]  rn_idx,
    output logic [31:0] rn_data,
    output logic        done,
    output logic        abort
);

`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StIdle, StAccess, StResult, StAbort} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAccess, StResult} state_e;
`endif

    state_e      state;

    // Request fields latched on accept
    logic        load_q;
    logic [1:0]  sh_q;
    logic        wb_en_q;
    logic [3:0]  rd_q;
    logic [3:0]  rn_q;
    logic [31:0] eff_q;

    // Request-side address and lane decode
    logic [31:0] eff_c;
    logic [31:0] addr_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        half_c;
    logic        wb_en_c;

    // Load-side lane extraction
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
    logic [31:0] ext_c;

`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
    logic        misalign_c;
    logic        misalign_q;
`endif

    // Decode the incoming request into address, lanes and store data
    always_comb begin
        half_c  = (req_sh != 2'b10);
        eff_c   = req_up ? (req_base + req_offset) : (req_base - req_offset);
        addr_c  = req_pre ? eff_c : req_base;
`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
        misalign_c = half_c && addr_c[0];
`else
        // Halfword accesses are silently forced onto a halfword boundary
        if (half_c) begin
            addr_c[0] = 1'b0;
        end
`endif
        wb_en_c = !req_pre || req_wb;
        if (half_c) begin
            be_c    = addr_c[1] ? 4'b1100 : 4'b0011;
            wdata_c = {req_sdata[15:0], req_sdata[15:0]};
        end else begin
            be_c    = 4'b0001 << addr_c[1:0];
            wdata_c = {4{req_sdata[7:0]}};
        end
    end

    // Select the addressed lane of the read data and extend it
    always_comb begin
        half_lane = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (mem_addr[1:0])
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        case (sh_q)
            2'b01:   ext_c = {16'h0000, half_lane};
            2'b10:   ext_c = {{24{byte_lane[7]}}, byte_lane};
            default: ext_c = {{16{half_lane[15]}}, half_lane};
        endcase
    end

`ifndef ARM7TDMI_HW_ALIGN_CHECK_EN
    assign abort = 1'b0;
`endif

    // Main sequencer: single FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            req_ready  <= 1'b0;
            load_q     <= 1'b0;
            sh_q       <= 2'b00;
            wb_en_q    <= 1'b0;
            rd_q       <= 4'd0;
            rn_q       <= 4'd0;
            eff_q      <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            rd_we      <= 1'b0;
            rd_idx     <= 4'd0;
            rd_data    <= 32'd0;
            rn_we      <= 1'b0;
            rn_idx     <= 4'd0;
            rn_data    <= 32'd0;
            done       <= 1'b0;
`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
            abort      <= 1'b0;
            misalign_q <= 1'b0;
`endif
        end else begin
            // Completion strobes are single-cycle pulses
            done  <= 1'b0;
            rd_we <= 1'b0;
            rn_we <= 1'b0;
`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
            abort <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        load_q    <= req_load;
                        sh_q      <= req_sh;
                        wb_en_q   <= wb_en_c;
                        rd_q      <= req_rd;
                        rn_q      <= req_rn;
                        eff_q     <= eff_c;
                        mem_addr  <= addr_c;
                        mem_wdata <= wdata_c;
`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
                        misalign_q <= misalign_c;
                        // A misaligned access never reaches the memory port
                        mem_be     <= misalign_c ? 4'b0000 : be_c;
                        mem_we     <= !misalign_c && !req_load;
                        mem_re     <= !misalign_c && req_load;
`else
                        mem_be     <= be_c;
                        mem_we     <= !req_load;
                        mem_re     <= req_load;
`endif
                        state     <= StAccess;
                    end
                end
                StAccess: begin
`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
                    if (misalign_q) begin
                        abort <= 1'b1;
                        state <= StAbort;
                    end else
`endif
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        mem_be <= 4'd0;
                        done   <= 1'b1;
                        if (load_q) begin
                            rd_we   <= 1'b1;
                            rd_idx  <= rd_q;
                            rd_data <= ext_c;
                        end
                        // On a load into the base register the loaded value wins
                        if (wb_en_q && !(load_q && (rd_q == rn_q))) begin
                            rn_we   <= 1'b1;
                            rn_idx  <= rn_q;
                            rn_data <= eff_q;
                        end
                        state  <= StResult;
                    end
                end
                StResult: begin
                    req_ready <= 1'b1;
                    state     <= StIdle;
                end
`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
                StAbort: begin
                    req_ready <= 1'b1;
                    state     <= StIdle;
                end
`endif
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm7tdmi_hw_mem_ctrl.sv
// Self-checking bench for arm7tdmi_hw_mem_ctrl: directed cases plus randomized
// transactions compared against an arithmetic reference model.
// Honours ARM7TDMI_HW_ALIGN_CHECK_EN for the misaligned-halfword expectations.
module tb_arm7tdmi_hw_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_load, req_pre, req_up, req_wb;
    logic [1:0]  req_sh;
    logic [31:0] req_base, req_offset, req_sdata;
    logic [3:0]  req_rd, req_rn;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_we, mem_re, mem_ready;
    logic        rd_we, rn_we, done, abort;
    logic [3:0]  rd_idx, rn_idx;
    logic [31:0] rd_data, rn_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arm7tdmi_hw_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_sh     (req_sh),
        .req_pre    (req_pre),
        .req_up     (req_up),
        .req_wb     (req_wb),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_sdata  (req_sdata),
        .req_rd     (req_rd),
        .req_rn     (req_rn),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .rd_we      (rd_we),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rn_we      (rn_we),
        .rn_idx     (rn_idx),
        .rn_data    (rn_data),
        .done       (done),
        .abort      (abort)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic scramble_req();
        req_load   = 1'($urandom);
        req_sh     = 2'($urandom);
        req_pre    = 1'($urandom);
        req_up     = 1'($urandom);
        req_wb     = 1'($urandom);
        req_base   = $urandom;
        req_offset = $urandom;
        req_sdata  = $urandom;
        req_rd     = 4'($urandom);
        req_rn     = 4'($urandom);
    endtask

    // Waits (bounded) for req_ready; called and returns at a negedge
    task automatic wait_ready();
        int budget = 0;
        while (req_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (req_ready !== 1'b1) check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // One complete transaction checked against the reference model
    task automatic run_txn(input logic load, input logic [1:0] sh, input logic pre,
                           input logic up, input logic wb, input logic [31:0] base,
                           input logic [31:0] offset, input logic [31:0] sdata,
                           input logic [3:0] rd, input logic [3:0] rn, input int waits,
                           input logic [31:0] rdata);
        logic [31:0] eff, addr, wdata, ext, v;
        logic [3:0]  be;
        logic        is_half, abort_exp, rn_exp;
        int          lane;

        eff       = up ? base + offset : base - offset;
        addr      = pre ? eff : base;
        is_half   = (sh != 2'b10);
        abort_exp = 1'b0;
`ifdef ARM7TDMI_HW_ALIGN_CHECK_EN
        if (is_half && (addr % 2 == 1)) abort_exp = 1'b1;
`else
        if (is_half) addr = addr & 32'hFFFF_FFFE;
`endif
        lane = int'(addr % 4);
        if (is_half) begin
            be    = (lane >= 2) ? 4'b1100 : 4'b0011;
            wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
            v     = (rdata >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
            ext   = (sh == 2'b11 && v >= 32'h8000) ? v + 32'hFFFF_0000 : v;
        end else begin
            be    = 4'(1 << lane);
            wdata = (sdata & 32'hFF) * 32'h0101_0101;
            v     = (rdata >> (8 * lane)) & 32'hFF;
            ext   = (v >= 32'h80) ? v - 32'd256 : v;
        end
        rn_exp = (!pre || wb) && !(load && rd == rn);

        wait_ready();
        req_valid = 1'b1;
        req_load = load; req_sh = sh; req_pre = pre; req_up = up; req_wb = wb;
        req_base = base; req_offset = offset; req_sdata = sdata; req_rd = rd; req_rn = rn;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble_req();
        @(negedge clk);
        check_eq("ready_busy", {31'd0, req_ready}, 32'd0);

        if (abort_exp) begin
            check_eq("abort_we", {31'd0, mem_we}, 32'd0);
            check_eq("abort_re", {31'd0, mem_re}, 32'd0);
            check_eq("abort_be", {28'd0, mem_be}, 32'd0);
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            check_eq("abort_pulse", {31'd0, abort}, 32'd1);
            check_eq("abort_done", {31'd0, done}, 32'd0);
            check_eq("abort_rdwe", {31'd0, rd_we}, 32'd0);
            check_eq("abort_rnwe", {31'd0, rn_we}, 32'd0);
            @(negedge clk);
            check_eq("abort_clear", {31'd0, abort}, 32'd0);
            check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
            return;
        end

        for (int w = 0; w <= waits; w++) begin
            check_eq("addr", mem_addr, addr);
            check_eq("be", {28'd0, mem_be}, {28'd0, be});
            check_eq("we", {31'd0, mem_we}, {31'd0, !load});
            check_eq("re", {31'd0, mem_re}, {31'd0, load});
            if (!load) check_eq("wdata", mem_wdata, wdata);
            check_eq("early_done", {31'd0, done}, 32'd0);
            mem_ready = (w == waits);
            mem_rdata = (w == waits) ? rdata : $urandom;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        check_eq("done", {31'd0, done}, 32'd1);
        check_eq("abort_none", {31'd0, abort}, 32'd0);
        check_eq("post_we", {31'd0, mem_we}, 32'd0);
        check_eq("post_re", {31'd0, mem_re}, 32'd0);
        check_eq("rd_we", {31'd0, rd_we}, {31'd0, load});
        if (load) begin
            check_eq("rd_idx", {28'd0, rd_idx}, {28'd0, rd});
            check_eq("rd_data", rd_data, ext);
        end
        check_eq("rn_we", {31'd0, rn_we}, {31'd0, rn_exp});
        if (rn_exp) begin
            check_eq("rn_idx", {28'd0, rn_idx}, {28'd0, rn});
            check_eq("rn_data", rn_data, eff);
        end
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        check_eq("rdwe_pulse", {31'd0, rd_we}, 32'd0);
        check_eq("rnwe_pulse", {31'd0, rn_we}, 32'd0);
        check_eq("ready_again", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        scramble_req();
        #2;
        check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_re", {31'd0, mem_re}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_abort", {31'd0, abort}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // STRH zero wait states
        run_txn(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 32'h2000, 32'd2, 32'h0000_DEAD, 4'd1, 4'd2,
                0, 32'd0);
        // LDRSB byte lane 1, negative then positive
        run_txn(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 32'h2011, 32'd0, 32'd0, 4'd3, 4'd4,
                0, 32'h0000_8000);
        run_txn(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 32'h2011, 32'd0, 32'd0, 4'd3, 4'd4,
                0, 32'h0000_7F00);
        // LDRSH pre-index with writeback, then LDRH post-index down
        run_txn(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 32'h2020, 32'd4, 32'd0, 4'd5, 4'd6,
                0, 32'h0000_8000);
        run_txn(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h2000, 32'd8, 32'd0, 4'd7, 4'd8,
                0, 32'hABCD_1234);
        // Three wait states
        run_txn(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h3002, 32'd0, 32'd0, 4'd9, 4'd10,
                3, 32'h5678_9ABC);
        // Misaligned LDRH at 0x2001
        run_txn(1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h2001, 32'd0, 32'd0, 4'd11, 4'd12,
                0, 32'h1357_2468);
        // Rd == Rn with writeback
        run_txn(1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 32'h4000, 32'd2, 32'd0, 4'd5, 4'd5,
                0, 32'hFEDC_0000);

        // Reset during a wait cycle kills the access
        wait_ready();
        req_valid = 1'b1;
        req_load = 1'b1; req_sh = 2'b01; req_pre = 1'b1; req_up = 1'b1; req_wb = 1'b1;
        req_base = 32'h5000; req_offset = 32'd0; req_rd = 4'd1; req_rn = 4'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("kill_re_before", {31'd0, mem_re}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("kill_re", {31'd0, mem_re}, 32'd0);
        check_eq("kill_we", {31'd0, mem_we}, 32'd0);
        check_eq("kill_addr", mem_addr, 32'd0);
        check_eq("kill_be", {28'd0, mem_be}, 32'd0);
        check_eq("kill_ready", {31'd0, req_ready}, 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("kill_done", {31'd0, done}, 32'd0);
            check_eq("kill_rdwe", {31'd0, rd_we}, 32'd0);
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 32'h6003, 32'd1, 32'h0000_00A5, 4'd2, 4'd3,
                1, 32'd0);

        // Randomized transactions
        for (int t = 0; t < 80; t++) begin
            logic [1:0]  sh;
            logic [31:0] off;
            logic [3:0]  rd, rn;
            sh  = 2'($urandom_range(1, 3));
            off = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            rd  = 4'($urandom);
            rn  = ($urandom_range(0, 3) == 0) ? rd : 4'($urandom);
            run_txn(1'($urandom), sh, 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                    off, $urandom, rd, rn, int'($urandom_range(0, 3)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
